// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM state encoding
// and the registered flag bundle.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef struct packed {
        logic overflow;
        logic zero;
        logic negative;
        logic carry;
    } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier, one multiplier bit per clock. Bit 0 is
// folded in on the start edge so the full product is ready WIDTH cycles later.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            acc_d    = B[0] ? {{WIDTH{1'b0}}, A} : '0;
            mcand_d  = {{(WIDTH-1){1'b0}}, A, 1'b0};
            mplier_d = {1'b0, B[WIDTH-1:1]};
            cnt_d    = CW'(1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (cnt_q != LAST) begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
            end else begin
                // Result has been presented for one cycle; go quiet.
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign done    = busy_q && (cnt_q == LAST);
    assign product = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags; logic and add/sub ops finish
// on the accept edge, MUL is handed to the iterative multiplier.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             carry
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    flags_t           flags_q, flags_d;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .A       (A),
        .B       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    // Shared adder: ADD uses B, SUB and SLT use ~B + 1.
    logic             is_add;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             carry_into_msb;
    logic             ovf_as;

    assign is_add         = (control == OP_ADD);
    assign b_eff          = is_add ? B : ~B;
    assign sum_ext        = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ~is_add};
    assign carry_into_msb = sum_ext[WIDTH-1] ^ A[WIDTH-1] ^ b_eff[WIDTH-1];
    assign ovf_as         = carry_into_msb ^ sum_ext[WIDTH];

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_carry;

    always_comb begin
        alu_res   = '0;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        case (control)
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOR: alu_res = ~(A | B);
            OP_ADD, OP_SUB: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_ovf   = ovf_as;
                alu_carry = sum_ext[WIDTH];
            end
            // Sign of the true difference, corrected for signed overflow.
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ ovf_as};
            default: alu_res = '0;
        endcase
    end

    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;

    assign mul_lo    = mul_product[WIDTH-1:0];
    assign mul_hi_nz = |mul_product[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        flags_d   = flags_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (control == OP_MUL) begin
                        state_d   = ST_BUSY;
                        mul_start = 1'b1;
                    end else begin
                        state_d          = ST_DONE;
                        out_d            = alu_res;
                        flags_d.overflow = alu_ovf;
                        flags_d.zero     = (alu_res == '0);
                        flags_d.negative = alu_res[WIDTH-1];
                        flags_d.carry    = alu_carry;
                    end
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d          = ST_DONE;
                    out_d            = mul_lo;
                    flags_d.overflow = mul_hi_nz;
                    flags_d.zero     = (mul_lo == '0);
                    flags_d.negative = mul_lo[WIDTH-1];
                    flags_d.carry    = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;
    assign carry     = flags_q.carry;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit and an 8-bit instance share clock
// and reset; expected results are hand-computed constants.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk;
    logic rst_n;

    logic        iv32, ir32, ov32, ordy32, of32, z32, n32, c32;
    logic [31:0] a32, b32, out32;
    logic [2:0]  ctl32;

    logic        iv8, ir8, ov8, ordy8, of8, z8, n8, c8;
    logic [7:0]  a8, b8, out8;
    logic [2:0]  ctl8;

    int tests_run;
    int tests_failed;

    alu_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .A(a32), .B(b32), .control(ctl32), .out_valid(ov32),
        .out_ready(ordy32), .out(out32), .overflow(of32), .zero(z32),
        .negative(n32), .carry(c32)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .control(ctl8), .out_valid(ov8),
        .out_ready(ordy8), .out(out8), .overflow(of8), .zero(z8),
        .negative(n8), .carry(c8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cur_out(input bit w8);
        return w8 ? {24'b0, out8} : out32;
    endfunction

    function automatic logic [3:0] cur_flags(input bit w8);
        return w8 ? {of8, z8, n8, c8} : {of32, z32, n32, c32};
    endfunction

    function automatic logic cur_valid(input bit w8);
        return w8 ? ov8 : ov32;
    endfunction

    function automatic logic cur_ready(input bit w8);
        return w8 ? ir8 : ir32;
    endfunction

    // Issue one op, wait for the result, check it and latency, then consume.
    // exp_flags order: {overflow, zero, negative, carry}.
    task automatic run_op(input bit w8, input string tag, input logic [2:0] ctl,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input logic [3:0] exp_flags,
                          input int exp_lat);
        int lat;
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; ctl8 = ctl; iv8 = 1'b1; ordy8 = 1'b0;
        end else begin
            a32 = a; b32 = b; ctl32 = ctl; iv32 = 1'b1; ordy32 = 1'b0;
        end
        check({tag, "/in_ready"}, 64'(cur_ready(w8)), 64'd1);
        tick();
        iv8 = 1'b0;
        iv32 = 1'b0;
        lat = 1;
        while (!cur_valid(w8) && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "/out"}, 64'(cur_out(w8)), 64'(exp_out));
        check({tag, "/flags"}, 64'(cur_flags(w8)), 64'(exp_flags));
        $display("[TB] %s A=%0h B=%0h -> out=%0h flags=%b latency=%0d",
                 tag, a, b, cur_out(w8), cur_flags(w8), lat);
        if (w8) ordy8 = 1'b1; else ordy32 = 1'b1;
        tick();
        ordy8 = 1'b0;
        ordy32 = 1'b0;
        check({tag, "/consumed"}, 64'({cur_valid(w8), cur_ready(w8)}), 64'b01);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        iv32 = 1'b1; a32 = 32'd1; b32 = 32'd1; ctl32 = OP_ADD; ordy32 = 1'b0;
        iv8 = 1'b1;  a8 = 8'd1;   b8 = 8'd1;   ctl8 = OP_ADD;  ordy8 = 1'b0;

        // Reset held two cycles with in_valid asserted.
        tick();
        check("rst/valid32_c1", 64'(ov32), 64'd0);
        tick();
        check("rst/out32", 64'(out32), 64'd0);
        check("rst/flags32", 64'({of32, z32, n32, c32}), 64'd0);
        check("rst/out8", 64'({out8, of8, z8, n8, c8}), 64'd0);
        check("rst/valid", 64'({ov32, ov8}), 64'd0);
        rst_n = 1'b1;
        iv32 = 1'b0;
        iv8 = 1'b0;
        tick();
        check("rst/ready_after", 64'({ir32, ir8}), 64'b11);
        check("rst/no_spurious", 64'({ov32, ov8}), 64'd0);
        $display("[TB] reset sequence done");

        run_op(0, "add_ovf",  OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1010, 1);
        run_op(0, "add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0,        4'b0101, 1);
        run_op(0, "sub_eq",   OP_SUB, 32'd5,        32'd5, 32'h0,        4'b0101, 1);
        run_op(0, "sub_neg",  OP_SUB, 32'd3,        32'd5, 32'hFFFFFFFE, 4'b0010, 1);
        run_op(0, "slt_ovf",  OP_SLT, 32'h80000000, 32'd1, 32'd1,        4'b0000, 1);
        run_op(0, "slt_gt",   OP_SLT, 32'd5,        32'd3, 32'd0,        4'b0100, 1);
        run_op(0, "or",       OP_OR,  32'h00F0000F, 32'h0F00000F, 32'h0FF0000F, 4'b0000, 1);
        run_op(0, "xor",      OP_XOR, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 4'b0000, 1);
        run_op(0, "nor",      OP_NOR, 32'h0,        32'h0, 32'hFFFFFFFF, 4'b0010, 1);
        run_op(1, "mul8_ovf", OP_MUL, 32'h10,       32'h10, 32'h0,       4'b1100, 9);
        run_op(1, "mul8_63",  OP_MUL, 32'd7,        32'd9,  32'd63,      4'b0000, 9);
        run_op(1, "mul8_neg", OP_MUL, 32'h0F,       32'h0F, 32'hE1,      4'b0010, 9);
        run_op(0, "mul32",    OP_MUL, 32'h1234,     32'h100, 32'h123400, 4'b0000, 33);

        // Backpressure: AND result held while new requests are offered.
        a32 = 32'hF0F0F0F0; b32 = 32'hFF00FF00; ctl32 = OP_AND; iv32 = 1'b1; ordy32 = 1'b0;
        tick();
        a32 = 32'h12345678; b32 = 32'h1; ctl32 = OP_ADD;
        for (int i = 0; i < 5; i++) begin
            check("bp/out", 64'(out32), 64'hF000F000);
            check("bp/flags", 64'({of32, z32, n32, c32}), 64'b0010);
            check("bp/hs", 64'({ov32, ir32}), 64'b10);
            tick();
        end
        $display("[TB] backpressure held out=%0h for 5 cycles", out32);
        ordy32 = 1'b1;
        iv32 = 1'b0;
        tick();
        ordy32 = 1'b0;
        check("bp/release", 64'({ov32, ir32}), 64'b01);

        // Reset in the third BUSY cycle of a 32-bit MUL.
        a32 = 32'd3; b32 = 32'd5; ctl32 = OP_MUL; iv32 = 1'b1;
        tick();
        iv32 = 1'b0;
        tick();
        tick();
        check("abort/busy", 64'({ov32, ir32}), 64'b00);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort/out", 64'(out32), 64'd0);
        check("abort/flags", 64'({of32, z32, n32, c32}), 64'd0);
        check("abort/hs", 64'({ov32, ir32}), 64'b01);
        $display("[TB] reset during MUL aborted the op");
        run_op(0, "add_after", OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
